// File: rtl/i2s_rx.sv
// I2S slave receiver: oversampled SCK/WS/SD, Philips framing, left/right pair on valid/ready.
// Optional I2S_RX_FRAME_CHECK_EN adds a frame_err pulse for words closing with a short/long count.
module i2s_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2s_sck,
  input  logic             i2s_ws,
  input  logic             i2s_sd,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             valid,
  input  logic             ready,
  output logic             overflow
`ifdef I2S_RX_FRAME_CHECK_EN
  ,
  output logic             frame_err
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CntFull = CW'(WIDTH);
  localparam logic [CW-1:0] CntMax  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

  state_e r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_ws_sync, r_sd_sync;
  logic                   r_sck_prev, r_ws_prev;
  logic [WIDTH-1:0]       r_shift, r_left_hold, r_left, r_right;
  logic [CW-1:0]          r_cnt;
  logic                   r_valid, r_overflow;

  logic             w_sck, w_ws, w_sd, w_strobe, w_ws_edge;
  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_cnt_next;
  logic             w_left_close, w_pair_done, w_load, w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
      r_sck_prev <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i2s_sck};
      r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], i2s_ws};
      r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], i2s_sd};
      r_sck_prev <= w_sck;
    end
  end

  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_ws      = r_ws_sync[SYNC_STAGES-1];
  assign w_sd      = r_sd_sync[SYNC_STAGES-1];
  assign w_strobe  = w_sck & ~r_sck_prev;
  assign w_ws_edge = w_strobe && (w_ws != r_ws_prev);

  // Word as it stands including this strobe's bit; bits past WIDTH fall off.
  always_comb begin
    w_word = r_shift;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_cnt == CW'(WIDTH - 1 - i)) w_word[i] = w_sd;
    end
    w_cnt_next = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StSync;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_left_close = 1'b0;
    w_pair_done  = 1'b0;
    if (w_ws_edge) begin
      case (r_state)
        StSync:  if (!w_ws) w_state_next = StLeft;
        StLeft:  if (w_ws) begin
          w_state_next = StRight;
          w_left_close = 1'b1;
        end
        StRight: if (!w_ws) begin
          w_state_next = StLeft;
          w_pair_done  = 1'b1;
        end
        default: w_state_next = StSync;
      endcase
    end
  end

  assign w_load = w_pair_done && (!r_valid || ready);
  assign w_drop = w_pair_done && r_valid && !ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ws_prev   <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_left_hold <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_strobe) begin
        r_ws_prev <= w_ws;
        if (w_ws != r_ws_prev) begin
          r_shift <= '0;
          r_cnt   <= '0;
        end else begin
          r_shift <= w_word;
          r_cnt   <= w_cnt_next;
        end
      end
      if (w_left_close) r_left_hold <= w_word;
      r_overflow <= w_drop;
      if (w_load) begin
        r_left  <= r_left_hold;
        r_right <= w_word;
        r_valid <= 1'b1;
      end else if (ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign left_data  = r_left;
  assign right_data = r_right;
  assign valid      = r_valid;
  assign overflow   = r_overflow;

`ifdef I2S_RX_FRAME_CHECK_EN
  logic r_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_ws_edge && (r_state != StSync) && (w_cnt_next != CntFull);
  end

  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bit-banged I2S master, expected pairs queued and
// compared by a monitor on every accepted valid.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2s_sck = 1'b0;
  logic        i2s_ws = 1'b0;
  logic        i2s_sd = 1'b0;
  logic [15:0] left_data, right_data;
  logic        valid;
  logic        ready = 1'b1;
  logic        overflow;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic        frame_err;
  int          fe_cnt = 0;
  int          fe_base;
`endif

  int          total = 0;
  int          bad = 0;
  int          ovf_cnt = 0;
  int          ovf_base;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  i2s_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i2s_sck    (i2s_sck),
    .i2s_ws     (i2s_ws),
    .i2s_sd     (i2s_sd),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .ready      (ready),
    .overflow   (overflow)
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Monitor: each accepted pair must match the oldest queued expectation.
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
`ifdef I2S_RX_FRAME_CHECK_EN
    if (frame_err) fe_cnt++;
`endif
    if (!rst && valid && ready) begin
      check("pair_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("pair_data", {left_data, right_data}, exp_q.pop_front());
    end
  end

  // SCK = clk/8; WS/SD change while SCK is low, sampled on SCK rise.
  task automatic send_bit(input logic ws, input logic sd);
    i2s_sck = 1'b0;
    i2s_ws  = ws;
    i2s_sd  = sd;
    repeat (4) @(posedge clk);
    i2s_sck = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Philips framing: the LSB goes out with WS already toggled to the next channel.
  task automatic send_chan(input logic ws, input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? ~ws : ws, data[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_chan(1'b0, l, n);
    send_chan(1'b1, r, n);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] part;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_left", {16'b0, left_data}, 32'd0);
    check("rst_right", {16'b0, right_data}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    rst = 1'b0;

    // Basic pair after a sync preamble
    send_chan(1'b1, 32'h0, 4);
    exp_q.push_back(32'hA5C3_1234);
    send_frame(32'hA5C3, 32'h1234, 16);
    drain("basic_drain");
    check("basic_valid_low", {31'b0, valid}, 32'd0);
    check("basic_no_overflow", ovf_cnt, 32'd0);

    // Backpressure: second pair dropped, first held
    ready = 1'b0;
    ovf_base = ovf_cnt;
    send_frame(32'h1111, 32'h2222, 16);
    send_frame(32'h3333, 32'h4444, 16);
    repeat (10) @(negedge clk);
    check("bp_valid_held", {31'b0, valid}, 32'd1);
    check("bp_data_held", {left_data, right_data}, 32'h1111_2222);
    check("bp_overflow_once", ovf_cnt - ovf_base, 32'd1);
    exp_q.push_back(32'h1111_2222);
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", {31'b0, valid}, 32'd0);
    drain("bp_drain");

    // Short words are left-justified and zero-filled
`ifdef I2S_RX_FRAME_CHECK_EN
    fe_base = fe_cnt;
`endif
    exp_q.push_back(32'hABC0_1230);
    send_frame(32'hABC, 32'h123, 12);
    drain("short_drain");
`ifdef I2S_RX_FRAME_CHECK_EN
    check("short_frame_err", fe_cnt - fe_base, 32'd2);
    fe_base = fe_cnt;
`endif

    // Long words are truncated to the top WIDTH bits
    exp_q.push_back(32'hFEDC_0123);
    send_frame(32'hFEDCB, 32'h01234, 20);
    drain("long_drain");
`ifdef I2S_RX_FRAME_CHECK_EN
    check("long_frame_err", fe_cnt - fe_base, 32'd2);
`endif

    // Stream joins mid-right-word after reset
    pulse_reset();
    send_chan(1'b1, 32'h3C, 8);
    repeat (10) @(negedge clk);
    check("midjoin_no_valid", {31'b0, valid}, 32'd0);
    exp_q.push_back(32'h5A5A_C3C3);
    send_frame(32'h5A5A, 32'hC3C3, 16);
    drain("midjoin_drain");

    // Reset during a left word while a pair is held
    ready = 1'b0;
    send_frame(32'h7777, 32'h8888, 16);
    repeat (10) @(negedge clk);
    check("hold_before_rst", {left_data, right_data}, 32'h7777_8888);
    part = 16'hABCD;
    for (int i = 15; i >= 8; i--) send_bit(1'b0, part[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_left", {16'b0, left_data}, 32'd0);
    check("mid_rst_right", {16'b0, right_data}, 32'd0);
    check("mid_rst_overflow", {31'b0, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(i == 0, part[i]);
    send_chan(1'b1, 32'h5555, 16);
    repeat (10) @(negedge clk);
    check("post_rst_no_valid", {31'b0, valid}, 32'd0);
    exp_q.push_back(32'h9999_6666);
    send_frame(32'h9999, 32'h6666, 16);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
